cpu_ctrl_fsm: RTL and testbench

Multi-cycle control sequencer for the single-ported RV32I core. It walks each instruction through FETCH, DECODE, EXEC, MEM and WB. It drives every datapath select and enable: immediate type, ALU sources, PC update, register-file write and memory request. It sits between the instruction register and the datapath, shares the one memory port between instruction fetch and data access, and holds the core in a trap state on illegal encodings.

---
 rtl/cpu_ctrl_fsm_pkg.sv | 59 +++++
 rtl/cpu_ctrl_fsm_if.sv | 34 +++
 rtl/cpu_ctrl_fsm_opdec.sv | 39 +++
 rtl/cpu_ctrl_fsm.sv | 123 ++++++++++++
 tb/tb_cpu_ctrl_fsm.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_ctrl_fsm_pkg.sv
// Shared encodings for the multi-cycle RV32I control sequencer: states, opcodes,
// instruction classes and datapath select codes.
package cpu_ctrl_fsm_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  // NONE sits at zero so the select bus is all-zero while fetching and in reset
  localparam logic [2:0] IMM_TYPE_NONE = 3'd0;
  localparam logic [2:0] IMM_TYPE_I    = 3'd1;
  localparam logic [2:0] IMM_TYPE_S    = 3'd2;
  localparam logic [2:0] IMM_TYPE_B    = 3'd3;
  localparam logic [2:0] IMM_TYPE_U    = 3'd4;
  localparam logic [2:0] IMM_TYPE_J    = 3'd5;

  localparam logic [1:0] PC_SEL_PC4  = 2'd0;
  localparam logic [1:0] PC_SEL_ALU  = 2'd1;
  localparam logic [1:0] PC_SEL_JALR = 2'd2;

  localparam logic [1:0] WB_SEL_ALU = 2'd0;
  localparam logic [1:0] WB_SEL_MEM = 2'd1;
  localparam logic [1:0] WB_SEL_PC4 = 2'd2;
  localparam logic [1:0] WB_SEL_IMM = 2'd3;

  typedef enum logic [3:0] {
    CLS_NONE, CLS_OP, CLS_OP_IMM, CLS_LOAD, CLS_STORE, CLS_BRANCH,
    CLS_JAL, CLS_JALR, CLS_LUI, CLS_AUIPC, CLS_FENCE
  } op_class_t;

  function automatic logic [2:0] imm_type_of(input op_class_t cls);
    case (cls)
      CLS_OP_IMM, CLS_LOAD, CLS_JALR: imm_type_of = IMM_TYPE_I;
      CLS_STORE:                      imm_type_of = IMM_TYPE_S;
      CLS_BRANCH:                     imm_type_of = IMM_TYPE_B;
      CLS_LUI, CLS_AUIPC:             imm_type_of = IMM_TYPE_U;
      CLS_JAL:                        imm_type_of = IMM_TYPE_J;
      default:                        imm_type_of = IMM_TYPE_NONE;
    endcase
  endfunction

endpackage

// File: rtl/cpu_ctrl_fsm_if.sv
// Control/datapath/memory bundle of the sequencer. The sequencer is the master;
// the datapath and memory port sit on the slave side.
interface cpu_ctrl_fsm_if;
  logic [31:0] i_inst;
  logic        i_br_taken;
  logic        i_mem_ack;
  logic        o_mem_req;
  logic        o_mem_we;
  logic        o_mem_addr_sel;
  logic        o_ir_we;
  logic [2:0]  o_imm_type;
  logic        o_alu_a_pc;
  logic        o_alu_b_imm;
  logic        o_pc_we;
  logic [1:0]  o_pc_sel;
  logic        o_rf_we;
  logic [1:0]  o_wb_sel;
  logic        o_retire;
  logic        o_illegal;

  modport master (
    input  i_inst, i_br_taken, i_mem_ack,
    output o_mem_req, o_mem_we, o_mem_addr_sel, o_ir_we, o_imm_type,
           o_alu_a_pc, o_alu_b_imm, o_pc_we, o_pc_sel, o_rf_we, o_wb_sel,
           o_retire, o_illegal
  );

  modport slave (
    output i_inst, i_br_taken, i_mem_ack,
    input  o_mem_req, o_mem_we, o_mem_addr_sel, o_ir_we, o_imm_type,
           o_alu_a_pc, o_alu_b_imm, o_pc_we, o_pc_sel, o_rf_we, o_wb_sel,
           o_retire, o_illegal
  );
endinterface

// File: rtl/cpu_ctrl_fsm_opdec.sv
// Combinational opcode/funct3 classifier: instruction class plus legal flag,
// consumed unregistered by the sequencer.
module cpu_ctrl_fsm_opdec
  import cpu_ctrl_fsm_pkg::*;
(
  input  logic [31:0] inst,
  output op_class_t   cls,
  output logic        legal
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       unused_fields;

  assign opcode        = inst[6:0];
  assign funct3        = inst[14:12];
  assign unused_fields = ^{inst[31:15], inst[11:7]};

  // Full 7-bit opcode match also rejects compressed encodings (inst[1:0] != 2'b11)
  always_comb begin
    cls   = CLS_NONE;
    legal = 1'b0;
    case (opcode)
      OPC_OP:     begin cls = CLS_OP;     legal = 1'b1; end
      OPC_OP_IMM: begin cls = CLS_OP_IMM; legal = 1'b1; end
      OPC_LOAD:   begin cls = CLS_LOAD;   legal = (funct3 != 3'd3) && (funct3 < 3'd6); end
      OPC_STORE:  begin cls = CLS_STORE;  legal = (funct3 < 3'd3); end
      OPC_BRANCH: begin cls = CLS_BRANCH; legal = (funct3 != 3'd2) && (funct3 != 3'd3); end
      OPC_JAL:    begin cls = CLS_JAL;    legal = 1'b1; end
      OPC_JALR:   begin cls = CLS_JALR;   legal = (funct3 == 3'd0); end
      OPC_LUI:    begin cls = CLS_LUI;    legal = 1'b1; end
      OPC_AUIPC:  begin cls = CLS_AUIPC;  legal = 1'b1; end
      OPC_FENCE:  begin cls = CLS_FENCE;  legal = 1'b1; end
      OPC_SYSTEM: begin cls = CLS_NONE;   legal = 1'b0; end
      default:    begin cls = CLS_NONE;   legal = 1'b0; end
    endcase
  end

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the single-ported RV32I core;
// drives all datapath selects/enables and parks in TRAP on illegal encodings.
module cpu_ctrl_fsm
  import cpu_ctrl_fsm_pkg::*;
(
  input logic           i_clk,
  input logic           i_rst,
  cpu_ctrl_fsm_if.master bus
);

  state_t    state;
  state_t    state_nxt;
  logic      run;
  op_class_t cls;
  logic      legal;
  logic      sel_valid;

  cpu_ctrl_fsm_opdec u_opdec (
    .inst  (bus.i_inst),
    .cls   (cls),
    .legal (legal)
  );

  // run holds off the first request until the first edge after reset release
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= ST_FETCH;
      run   <= 1'b0;
    end else begin
      state <= state_nxt;
      run   <= 1'b1;
    end
  end

  assign sel_valid = (state != ST_FETCH) && (state != ST_TRAP);

  always_comb begin
    state_nxt          = state;
    bus.o_mem_req      = 1'b0;
    bus.o_mem_we       = 1'b0;
    bus.o_mem_addr_sel = 1'b0;
    bus.o_ir_we        = 1'b0;
    bus.o_pc_we        = 1'b0;
    bus.o_pc_sel       = PC_SEL_PC4;
    bus.o_rf_we        = 1'b0;
    bus.o_wb_sel       = WB_SEL_ALU;
    bus.o_retire       = 1'b0;
    bus.o_illegal      = 1'b0;
    bus.o_imm_type     = (state == ST_FETCH) ? IMM_TYPE_NONE : imm_type_of(cls);
    bus.o_alu_a_pc     = sel_valid && (cls inside {CLS_AUIPC, CLS_JAL, CLS_BRANCH});
    bus.o_alu_b_imm    = sel_valid && (cls != CLS_OP) && (cls != CLS_NONE);

    case (state)
      ST_FETCH: begin
        if (run) begin
          bus.o_mem_req = 1'b1;
          if (bus.i_mem_ack) begin
            bus.o_ir_we = 1'b1;
            state_nxt   = ST_DECODE;
          end
        end
      end

      ST_DECODE: state_nxt = legal ? ST_EXEC : ST_TRAP;

      ST_EXEC: begin
        case (cls)
          CLS_LOAD, CLS_STORE: state_nxt = ST_MEM;
          CLS_BRANCH: begin
            bus.o_pc_we  = 1'b1;
            bus.o_pc_sel = bus.i_br_taken ? PC_SEL_ALU : PC_SEL_PC4;
            bus.o_retire = 1'b1;
            state_nxt    = ST_FETCH;
          end
          CLS_FENCE: begin
            bus.o_pc_we  = 1'b1;
            bus.o_retire = 1'b1;
            state_nxt    = ST_FETCH;
          end
          default: state_nxt = ST_WB;
        endcase
      end

      ST_MEM: begin
        bus.o_mem_req      = 1'b1;
        bus.o_mem_addr_sel = 1'b1;
        bus.o_mem_we       = (cls == CLS_STORE);
        if (bus.i_mem_ack) begin
          if (cls == CLS_STORE) begin
            bus.o_pc_we  = 1'b1;
            bus.o_retire = 1'b1;
            state_nxt    = ST_FETCH;
          end else begin
            state_nxt = ST_WB;
          end
        end
      end

      ST_WB: begin
        bus.o_rf_we  = 1'b1;
        bus.o_pc_we  = 1'b1;
        bus.o_retire = 1'b1;
        state_nxt    = ST_FETCH;
        case (cls)
          CLS_LOAD:          bus.o_wb_sel = WB_SEL_MEM;
          CLS_JAL, CLS_JALR: bus.o_wb_sel = WB_SEL_PC4;
          CLS_LUI:           bus.o_wb_sel = WB_SEL_IMM;
          default:           bus.o_wb_sel = WB_SEL_ALU;
        endcase
        case (cls)
          CLS_JAL:  bus.o_pc_sel = PC_SEL_ALU;
          CLS_JALR: bus.o_pc_sel = PC_SEL_JALR;
          default:  bus.o_pc_sel = PC_SEL_PC4;
        endcase
      end

      ST_TRAP: bus.o_illegal = 1'b1;

      default: state_nxt = ST_FETCH;
    endcase
  end

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Bench for cpu_ctrl_fsm: directed vector table, hand-written reset/trap sequences,
// and random instructions checked against an instruction-level reference model.
module tb_cpu_ctrl_fsm;
  import cpu_ctrl_fsm_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  cpu_ctrl_fsm_if bus();

  cpu_ctrl_fsm dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int tests  = 0;
  int failed = 0;

  // Per-instruction observation: cycle of retire (counted from first fetch cycle),
  // pulse counts, and selects captured at the enable/retire cycles.
  typedef struct {
    int lat, ir_we, rf_we, wb_sel, pc_we, pc_sel, retire, imm, a_pc, b_imm, mem_we, illegal;
  } obs_t;

  typedef struct {
    logic [31:0] inst;
    logic        br;
    int          fw, mw;
    obs_t        exp;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      failed++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic compare_obs(input string tag, input obs_t g, input obs_t e);
    check({tag, "_lat"},     g.lat,     e.lat);
    check({tag, "_ir_we"},   g.ir_we,   e.ir_we);
    check({tag, "_rf_we"},   g.rf_we,   e.rf_we);
    check({tag, "_wb_sel"},  g.wb_sel,  e.wb_sel);
    check({tag, "_pc_we"},   g.pc_we,   e.pc_we);
    check({tag, "_pc_sel"},  g.pc_sel,  e.pc_sel);
    check({tag, "_retire"},  g.retire,  e.retire);
    check({tag, "_imm"},     g.imm,     e.imm);
    check({tag, "_a_pc"},    g.a_pc,    e.a_pc);
    check({tag, "_b_imm"},   g.b_imm,   e.b_imm);
    check({tag, "_mem_we"},  g.mem_we,  e.mem_we);
    check({tag, "_illegal"}, g.illegal, e.illegal);
  endtask

  function automatic obs_t ex(int lat, int rf, int wb, int pcs, int imm, int apc, int bimm, int mwe);
    obs_t e;
    e.lat = lat; e.ir_we = 1; e.rf_we = rf; e.wb_sel = wb; e.pc_we = 1; e.pc_sel = pcs;
    e.retire = 1; e.imm = imm; e.a_pc = apc; e.b_imm = bimm; e.mem_we = mwe; e.illegal = 0;
    return e;
  endfunction

  function automatic obs_t ex_ill();
    obs_t e = '{default: 0};
    e.ir_we   = 1;
    e.illegal = 1;
    return e;
  endfunction

  // Reference model: instruction-level outcome from opcode/funct3 rules and wait counts.
  function automatic obs_t model(logic [31:0] inst, logic br, int fw, int mw);
    logic [6:0] opc;
    int f3, base, wb, pcs, imm, apc, bimm, mwe;
    bit ok;
    opc = inst[6:0];
    f3 = int'(inst[14:12]);
    ok = 1; base = 4; wb = -1; pcs = 0; imm = IMM_TYPE_NONE; apc = 0; bimm = 1; mwe = 0;
    case (opc)
      7'h33: begin wb = 0; bimm = 0; end
      7'h13: begin wb = 0; imm = IMM_TYPE_I; end
      7'h03: begin base = 5 + mw; wb = 1; imm = IMM_TYPE_I; ok = !(f3 inside {3, 6, 7}); end
      7'h23: begin base = 4 + mw; imm = IMM_TYPE_S; mwe = mw + 1; ok = (f3 < 3); end
      7'h63: begin base = 3; imm = IMM_TYPE_B; apc = 1; pcs = int'(br); ok = !(f3 inside {2, 3}); end
      7'h6f: begin wb = 2; pcs = 1; imm = IMM_TYPE_J; apc = 1; end
      7'h67: begin wb = 2; pcs = 2; imm = IMM_TYPE_I; ok = (f3 == 0); end
      7'h37: begin wb = 3; imm = IMM_TYPE_U; end
      7'h17: begin wb = 0; imm = IMM_TYPE_U; apc = 1; end
      7'h0f: base = 3;
      default: ok = 0;
    endcase
    if (!ok) return ex_ill();
    return ex(base + fw, (wb >= 0) ? 1 : 0, (wb >= 0) ? wb : 0, pcs, imm, apc, bimm, mwe);
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    bus.i_mem_ack  = 1'b0;
    bus.i_br_taken = 1'b0;
    bus.i_inst     = '0;
    @(negedge clk);
    #1;
    check("reset_outputs", int'({bus.o_mem_req, bus.o_mem_we, bus.o_mem_addr_sel, bus.o_ir_we,
          bus.o_imm_type, bus.o_alu_a_pc, bus.o_alu_b_imm, bus.o_pc_we, bus.o_pc_sel,
          bus.o_rf_we, bus.o_wb_sel, bus.o_retire}), 0);
    check("reset_illegal", bus.o_illegal, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_reset_req_low", bus.o_mem_req, 0);
  endtask

  // Memory acks after fw (fetch) / mw (data) wait cycles; ack is random whenever
  // no request is up, and br_taken is random outside the EXEC cycle of a branch.
  task automatic run_instr(input logic [31:0] inst, input logic br, input int fw, input int mw,
                           input int max_cyc, output obs_t o);
    int   cyc, reqn;
    logic fetched, done, pend, pend_sel, ill_seen, ack;
    o = '{default: 0};
    cyc = 0; reqn = 0; fetched = 0; done = 0; pend = 0; pend_sel = 0; ill_seen = 0;
    while (!done && cyc < max_cyc) begin
      @(negedge clk);
      cyc++;
      if (fetched) bus.i_inst = inst;
      #1;
      if (bus.o_mem_req) begin
        ack = (reqn == (fetched ? mw : fw));
        reqn++;
      end else begin
        ack = 1'($urandom_range(0, 1));
      end
      bus.i_mem_ack  = ack;
      bus.i_br_taken = (cyc == fw + 3) ? br : 1'($urandom_range(0, 1));
      #1;
      if (pend) begin
        check("req_held", bus.o_mem_req, 1);
        check("addr_sel_stable", bus.o_mem_addr_sel, pend_sel);
      end
      if (!fetched) begin
        check("imm_none_in_fetch", bus.o_imm_type, IMM_TYPE_NONE);
        if (bus.o_mem_req) check("fetch_addr_pc", bus.o_mem_addr_sel, 0);
      end else if (bus.o_mem_req) begin
        check("data_addr_alu", bus.o_mem_addr_sel, 1);
      end
      if (ill_seen) check("illegal_sticky", bus.o_illegal, 1);
      if (bus.o_illegal) begin
        ill_seen  = 1;
        o.illegal = 1;
        check("trap_quiet", int'({bus.o_mem_req, bus.o_ir_we, bus.o_pc_we, bus.o_rf_we, bus.o_retire}), 0);
      end
      o.ir_we += int'(bus.o_ir_we);
      o.rf_we += int'(bus.o_rf_we);
      o.pc_we += int'(bus.o_pc_we);
      if (bus.o_rf_we) o.wb_sel = int'(bus.o_wb_sel);
      if (bus.o_pc_we) o.pc_sel = int'(bus.o_pc_sel);
      if (bus.o_mem_req && bus.o_mem_we) o.mem_we++;
      if (bus.o_ir_we) begin
        fetched = 1;
        reqn    = 0;
      end
      if (bus.o_retire) begin
        o.retire++;
        o.lat   = cyc;
        o.imm   = int'(bus.o_imm_type);
        o.a_pc  = int'(bus.o_alu_a_pc);
        o.b_imm = int'(bus.o_alu_b_imm);
        done    = 1;
      end
      pend     = bus.o_mem_req && !ack;
      pend_sel = bus.o_mem_addr_sel;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    obs_t g, e;
    logic [6:0] opcs [11];
    logic [31:0] inst;
    logic br, seen;
    int sel, fw, mw;

    opcs = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6f, 7'h67, 7'h37, 7'h17, 7'h0f, 7'h73};

    tbl.push_back('{32'h00500093, 1'b0, 0, 0, ex(4, 1, 0, 0, IMM_TYPE_I,    0, 1, 0)}); // addi
    tbl.push_back('{32'h00012183, 1'b0, 0, 2, ex(7, 1, 1, 0, IMM_TYPE_I,    0, 1, 0)}); // lw, 2 waits
    tbl.push_back('{32'h00112023, 1'b0, 1, 1, ex(6, 0, 0, 0, IMM_TYPE_S,    0, 1, 2)}); // sw
    tbl.push_back('{32'h00000463, 1'b1, 0, 0, ex(3, 0, 0, 1, IMM_TYPE_B,    1, 1, 0)}); // beq taken
    tbl.push_back('{32'h00000463, 1'b0, 0, 0, ex(3, 0, 0, 0, IMM_TYPE_B,    1, 1, 0)}); // beq not taken
    tbl.push_back('{32'h010000ef, 1'b0, 0, 0, ex(4, 1, 2, 1, IMM_TYPE_J,    1, 1, 0)}); // jal
    tbl.push_back('{32'h123450b7, 1'b0, 0, 0, ex(4, 1, 3, 0, IMM_TYPE_U,    0, 1, 0)}); // lui
    tbl.push_back('{32'h00001117, 1'b0, 0, 0, ex(4, 1, 0, 0, IMM_TYPE_U,    1, 1, 0)}); // auipc
    tbl.push_back('{32'h000080e7, 1'b0, 0, 0, ex(4, 1, 2, 2, IMM_TYPE_I,    0, 1, 0)}); // jalr
    tbl.push_back('{32'h002081b3, 1'b0, 2, 0, ex(6, 1, 0, 0, IMM_TYPE_NONE, 0, 0, 0)}); // add, 2 fetch waits
    tbl.push_back('{32'h0ff0000f, 1'b0, 0, 0, ex(3, 0, 0, 0, IMM_TYPE_NONE, 0, 1, 0)}); // fence
    tbl.push_back('{32'h00000000, 1'b0, 0, 0, ex_ill()});                                // all zero
    tbl.push_back('{32'h00003003, 1'b0, 1, 0, ex_ill()});                                // load funct3=3
    tbl.push_back('{32'h00002063, 1'b0, 0, 0, ex_ill()});                                // branch funct3=2
    tbl.push_back('{32'h00000073, 1'b0, 0, 0, ex_ill()});                                // ecall

    bus.i_inst = '0; bus.i_mem_ack = 1'b0; bus.i_br_taken = 1'b0;
    do_reset();

    foreach (tbl[i]) begin
      run_instr(tbl[i].inst, tbl[i].br, tbl[i].fw, tbl[i].mw,
                tbl[i].exp.illegal ? tbl[i].fw + 7 : 40, g);
      compare_obs($sformatf("vec%0d", i), g, tbl[i].exp);
      if (tbl[i].exp.illegal || g.illegal) do_reset();
    end

    // Reset while a data request is outstanding: request must fall at once.
    bus.i_inst = 32'h00012183;
    @(negedge clk); #1; bus.i_mem_ack = 1'b1;
    @(negedge clk); bus.i_mem_ack = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 6 && !seen; k++) begin
      @(negedge clk); #1;
      if (bus.o_mem_req && bus.o_mem_addr_sel) seen = 1'b1;
    end
    check("reach_mem_phase", seen, 1);
    rst = 1'b1;
    #1;
    check("rst_drops_req_async", bus.o_mem_req, 0);
    check("rst_addr_sel_pc", bus.o_mem_addr_sel, 0);
    @(negedge clk); rst = 1'b0; #1;
    check("rst_release_req_low", bus.o_mem_req, 0);
    @(negedge clk); #1;
    check("refetch_req", bus.o_mem_req, 1);
    check("refetch_addr_pc", bus.o_mem_addr_sel, 0);

    for (int n = 0; n < 60; n++) begin
      sel  = $urandom_range(0, 11);
      inst = $urandom;
      if (sel < 11) inst[6:0] = opcs[sel];
      br = 1'($urandom_range(0, 1));
      fw = $urandom_range(0, 2);
      mw = $urandom_range(0, 2);
      e  = model(inst, br, fw, mw);
      run_instr(inst, br, fw, mw, e.illegal ? fw + 7 : 40, g);
      compare_obs($sformatf("rnd%0d_%08h", n, inst), g, e);
      if (e.illegal || g.illegal) do_reset();
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
